// File: rtl/frame_stats_pkg.sv
// Shared types and widths for the per-frame focus-statistics producer.
// Package only: no latency, no backpressure.
package frame_stats_pkg;

  localparam int PIX_W   = 8;
  localparam int SIGMA_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FINISH,
    ST_PUBLISH
  } state_t;

  // Worst-case sum of 2^log2_pix pixel-sized terms.
  function automatic int acc_width(input int log2_pix);
    return PIX_W + log2_pix;
  endfunction

endpackage

// File: rtl/frame_stats_absdiff.sv
// Registered absolute difference |a-b| of two pixels, with a qualifier.
// Latency 1 cycle; no backpressure (accepts every cycle).
module frame_stats_absdiff
  import frame_stats_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_vld,
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic             out_vld,
  output logic [PIX_W-1:0] out_dat
);

  logic             vld_d, vld_q;
  logic [PIX_W-1:0] diff_d, diff_q;

  always_comb begin
    vld_d  = in_vld;
    diff_d = (a >= b) ? (a - b) : (b - a);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      diff_q <= '0;
    end else begin
      vld_q  <= vld_d;
      diff_q <= diff_d;
    end
  end

  assign out_vld = vld_q;
  assign out_dat = diff_q;

endmodule

// File: rtl/frame_stats_tx.sv
// Per-frame mean intensity and gradient sharpness over the first 2^LOG2_PIX pixels.
// Latency: hz two edges after the eof beat; no backpressure (pixel stream is never stalled).
module frame_stats_tx
  import frame_stats_pkg::*;
#(
  parameter int LOG2_PIX = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic               pix_sof,
  input  logic               pix_sol,
  input  logic               pix_eof,
  output logic               hz,
  output logic [SIGMA_W-1:0] Sigma,
  output logic [PIX_W-1:0]   Imean,
  output logic               frame_short
);

  localparam int ACC_W = acc_width(LOG2_PIX);
  localparam int CNT_W = LOG2_PIX + 1;
  localparam logic [CNT_W-1:0] FULL = {1'b1, {LOG2_PIX{1'b0}}};

  state_t               state_d, state_q;
  logic [ACC_W-1:0]     int_sum_d, int_sum_q;
  logic [ACC_W-1:0]     grad_sum_d, grad_sum_q;
  logic [ACC_W-1:0]     grad_total;
  logic [CNT_W-1:0]     count_d, count_q;
  logic [PIX_W-1:0]     prev_d, prev_q;
  logic [SIGMA_W-1:0]   sigma_d, sigma_q;
  logic [PIX_W-1:0]     imean_d, imean_q;
  logic                 hz_d, hz_q;
  logic                 short_d, short_q;
  logic                 diff_in_vld, diff_vld;
  logic [PIX_W-1:0]     diff_dat;

  frame_stats_absdiff u_absdiff (
    .clock   (clock),
    .reset_n (reset_n),
    .in_vld  (diff_in_vld),
    .a       (pix_data),
    .b       (prev_q),
    .out_vld (diff_vld),
    .out_dat (diff_dat)
  );

  always_comb begin
    state_d     = state_q;
    int_sum_d   = int_sum_q;
    count_d     = count_q;
    prev_d      = prev_q;
    sigma_d     = sigma_q;
    imean_d     = imean_q;
    hz_d        = 1'b0;
    short_d     = short_q;
    diff_in_vld = 1'b0;
    // The gradient lags one cycle behind the beat; it drains here every cycle.
    grad_total  = diff_vld ? (grad_sum_q + {{LOG2_PIX{1'b0}}, diff_dat}) : grad_sum_q;
    grad_sum_d  = grad_total;

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (pix_valid) begin
          if (pix_sof) begin
            // sof is also sol, so any in-flight gradient belongs to the old frame.
            int_sum_d  = {{LOG2_PIX{1'b0}}, pix_data};
            grad_sum_d = '0;
            count_d    = {{(CNT_W-1){1'b0}}, 1'b1};
            prev_d     = pix_data;
            state_d    = ST_ACCUM;
          end else if (state_q == ST_ACCUM && count_q < FULL) begin
            int_sum_d   = int_sum_q + {{LOG2_PIX{1'b0}}, pix_data};
            count_d     = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            diff_in_vld = !pix_sol;
            prev_d      = pix_data;
          end
          if (pix_eof && (pix_sof || state_q == ST_ACCUM)) begin
            if (count_d < FULL) begin
              short_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_FINISH;
            end
          end
        end
      end
      ST_FINISH: begin
        imean_d = int_sum_q[ACC_W-1:LOG2_PIX];
        sigma_d = grad_total[ACC_W-1:LOG2_PIX-1];
        hz_d    = 1'b1;
        short_d = 1'b0;
        state_d = ST_PUBLISH;
      end
      ST_PUBLISH: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      int_sum_q  <= '0;
      grad_sum_q <= '0;
      count_q    <= '0;
      prev_q     <= '0;
      sigma_q    <= '0;
      imean_q    <= '0;
      hz_q       <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      int_sum_q  <= int_sum_d;
      grad_sum_q <= grad_sum_d;
      count_q    <= count_d;
      prev_q     <= prev_d;
      sigma_q    <= sigma_d;
      imean_q    <= imean_d;
      hz_q       <= hz_d;
      short_q    <= short_d;
    end
  end

  assign hz          = hz_q;
  assign Sigma       = sigma_q;
  assign Imean       = imean_q;
  assign frame_short = short_q;

endmodule

// File: tb/tb_frame_stats_tx.sv
// Bench for frame_stats_tx with 16-pixel windows (4 lines x 4 pixels).
// Expected statistics come from a plain arithmetic model of the frame contents.
module tb_frame_stats_tx;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic       pix_sof = 1'b0, pix_sol = 1'b0, pix_eof = 1'b0;
  logic       hz;
  logic [8:0] Sigma;
  logic [7:0] Imean;
  logic       frame_short;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fr [0:31];
  logic [8:0] held_s;
  logic [7:0] held_m;

  frame_stats_tx #(.LOG2_PIX(4)) dut (
    .clock(clock), .reset_n(reset_n), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_sol(pix_sol), .pix_eof(pix_eof),
    .hz(hz), .Sigma(Sigma), .Imean(Imean), .frame_short(frame_short)
  );

  always #5 clock = ~clock;

  // Window = first 16 pixels; gradient skips line starts; Imean = sum/16, Sigma = grad/8.
  task automatic model_frame(input int len, output bit sh, output logic [7:0] m, output logic [8:0] s);
    int n, sum, grad, d;
    n = (len < 16) ? len : 16;
    sum = 0;
    grad = 0;
    for (int i = 0; i < n; i++) begin
      sum += int'(fr[i]);
      if (i % 4 != 0) begin
        d = int'(fr[i]) - int'(fr[i-1]);
        grad += (d < 0) ? -d : d;
      end
    end
    sh = (len < 16);
    m  = 8'(sum / 16);
    s  = 9'(grad / 8);
  endtask

  // Drives fr[0..len-1] as a frame; returns #1 after the last beat's edge.
  task automatic send_frame(input int len, input bit do_eof, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        @(negedge clock);
        pix_valid = 1'b0;
        pix_data  = 8'($urandom);
        pix_sof = 1'b0; pix_sol = 1'b0; pix_eof = 1'b0;
        @(posedge clock);
      end
      @(negedge clock);
      pix_valid = 1'b1;
      pix_data  = fr[i];
      pix_sof   = (i == 0);
      pix_sol   = (i % 4 == 0);
      pix_eof   = do_eof && (i == len - 1);
      @(posedge clock);
    end
    #1;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_sol = 1'b0; pix_eof = 1'b0;
  endtask

  // Watches a bounded window after the eof edge; k=1 is the second edge after eof.
  task automatic observe(output int hz_cnt, output int lat, output logic [8:0] s,
                         output logic [7:0] m, output logic sh);
    hz_cnt = 0;
    lat = -1;
    s = '0; m = '0; sh = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge clock);
        #1;
      end
      if (hz === 1'b1) begin
        hz_cnt++;
        if (lat < 0) begin
          lat = k; s = Sigma; m = Imean; sh = frame_short;
        end
      end
    end
    if (lat < 0) begin
      s = Sigma; m = Imean; sh = frame_short;
    end
  endtask

  task automatic fill_const(input int len, input logic [7:0] v);
    for (int i = 0; i < len; i++) fr[i] = v;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (hz !== 1'b0) begin n_bad++; $display("FAIL reset_hz got=%b want=0", hz); end
    n_cmp++; if (Sigma !== 9'd0) begin n_bad++; $display("FAIL reset_sigma got=%0d want=0", Sigma); end
    n_cmp++; if (Imean !== 8'd0) begin n_bad++; $display("FAIL reset_imean got=%0d want=0", Imean); end
    n_cmp++; if (frame_short !== 1'b0) begin n_bad++; $display("FAIL reset_short got=%b want=0", frame_short); end
    @(negedge clock);
    reset_n = 1'b1;
    held_s = '0; held_m = '0;
  endtask

  task automatic test_const();
    int c, l; logic [8:0] s, es; logic [7:0] m, em; logic sh; bit esh;
    fill_const(16, 8'd100);
    model_frame(16, esh, em, es);
    send_frame(16, 1'b1, 1'b0);
    observe(c, l, s, m, sh);
    n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL const_hz_count got=%0d want=1", c); end
    n_cmp++; if (l !== 1) begin n_bad++; $display("FAIL const_latency got=%0d want=1", l); end
    n_cmp++; if (m !== em) begin n_bad++; $display("FAIL const_imean got=%0d want=%0d", m, em); end
    n_cmp++; if (s !== es) begin n_bad++; $display("FAIL const_sigma got=%0d want=%0d", s, es); end
    n_cmp++; if (sh !== 1'b0) begin n_bad++; $display("FAIL const_short got=%b want=0", sh); end
    held_s = es; held_m = em;
  endtask

  task automatic test_alternating();
    int c, l; logic [8:0] s; logic [7:0] m; logic sh;
    for (int i = 0; i < 16; i++) fr[i] = (i % 2 == 1) ? 8'd255 : 8'd0;
    send_frame(16, 1'b1, 1'b0);
    observe(c, l, s, m, sh);
    n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL alt_hz_count got=%0d want=1", c); end
    n_cmp++; if (s !== 9'd382) begin n_bad++; $display("FAIL alt_sigma got=%0d want=382", s); end
    n_cmp++; if (m !== 8'd127) begin n_bad++; $display("FAIL alt_imean got=%0d want=127", m); end
    held_s = 9'd382; held_m = 8'd127;
  endtask

  task automatic test_short_frame();
    int c, l; logic [8:0] s, es; logic [7:0] m, em; logic sh; bit esh;
    for (int i = 0; i < 10; i++) fr[i] = 8'($urandom);
    send_frame(10, 1'b1, 1'b0);
    observe(c, l, s, m, sh);
    n_cmp++; if (c !== 0) begin n_bad++; $display("FAIL short_hz_count got=%0d want=0", c); end
    n_cmp++; if (sh !== 1'b1) begin n_bad++; $display("FAIL short_flag got=%b want=1", sh); end
    n_cmp++; if (s !== held_s) begin n_bad++; $display("FAIL short_sigma_hold got=%0d want=%0d", s, held_s); end
    n_cmp++; if (m !== held_m) begin n_bad++; $display("FAIL short_imean_hold got=%0d want=%0d", m, held_m); end
    fill_const(16, 8'($urandom_range(1, 254)));
    model_frame(16, esh, em, es);
    send_frame(16, 1'b1, 1'b0);
    n_cmp++; if (frame_short !== 1'b1) begin n_bad++; $display("FAIL short_sticky got=%b want=1", frame_short); end
    observe(c, l, s, m, sh);
    n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL short_next_hz got=%0d want=1", c); end
    n_cmp++; if (sh !== 1'b0) begin n_bad++; $display("FAIL short_cleared got=%b want=0", sh); end
    n_cmp++; if (m !== em) begin n_bad++; $display("FAIL short_next_imean got=%0d want=%0d", m, em); end
    held_s = es; held_m = em;
  endtask

  task automatic test_restart();
    int c, l; logic [8:0] s; logic [7:0] m; logic sh;
    fill_const(8, 8'd100);
    send_frame(8, 1'b0, 1'b0);
    fill_const(16, 8'd50);
    send_frame(16, 1'b1, 1'b0);
    observe(c, l, s, m, sh);
    n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL restart_hz_count got=%0d want=1", c); end
    n_cmp++; if (m !== 8'd50) begin n_bad++; $display("FAIL restart_imean got=%0d want=50", m); end
    n_cmp++; if (s !== 9'd0) begin n_bad++; $display("FAIL restart_sigma got=%0d want=0", s); end
    held_s = 9'd0; held_m = 8'd50;
  endtask

  task automatic test_overlong();
    int c, l; logic [8:0] s; logic [7:0] m; logic sh;
    fill_const(16, 8'd80);
    for (int i = 16; i < 20; i++) fr[i] = 8'd255;
    send_frame(20, 1'b1, 1'b0);
    observe(c, l, s, m, sh);
    n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL long_hz_count got=%0d want=1", c); end
    n_cmp++; if (l !== 1) begin n_bad++; $display("FAIL long_latency got=%0d want=1", l); end
    n_cmp++; if (m !== 8'd80) begin n_bad++; $display("FAIL long_imean got=%0d want=80", m); end
    n_cmp++; if (s !== 9'd0) begin n_bad++; $display("FAIL long_sigma got=%0d want=0", s); end
    held_s = 9'd0; held_m = 8'd80;
  endtask

  task automatic test_reset_mid_frame();
    int c, l; logic [8:0] s; logic [7:0] m; logic sh;
    for (int i = 0; i < 8; i++) fr[i] = 8'($urandom_range(150, 255));
    send_frame(8, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (Imean !== 8'd0) begin n_bad++; $display("FAIL midrst_imean got=%0d want=0", Imean); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    fill_const(16, 8'd30);
    send_frame(16, 1'b1, 1'b0);
    n_cmp++; if (Imean !== 8'd0 || Sigma !== 9'd0) begin
      n_bad++; $display("FAIL midrst_pre_hz imean=%0d sigma=%0d want=0/0", Imean, Sigma);
    end
    observe(c, l, s, m, sh);
    n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL midrst_hz_count got=%0d want=1", c); end
    n_cmp++; if (m !== 8'd30) begin n_bad++; $display("FAIL midrst_imean_pub got=%0d want=30", m); end
    n_cmp++; if (s !== 9'd0) begin n_bad++; $display("FAIL midrst_sigma_pub got=%0d want=0", s); end
    held_s = 9'd0; held_m = 8'd30;
  endtask

  task automatic test_random_frames();
    int c, l, len; logic [8:0] s, es; logic [7:0] m, em; logic sh; bit esh;
    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(10, 20);
      for (int i = 0; i < len; i++) fr[i] = 8'($urandom);
      model_frame(len, esh, em, es);
      send_frame(len, 1'b1, 1'b1);
      observe(c, l, s, m, sh);
      if (!esh) begin
        held_s = es; held_m = em;
      end
      n_cmp++; if (c !== (esh ? 0 : 1)) begin n_bad++; $display("FAIL rand%0d_hz_count got=%0d len=%0d", f, c, len); end
      n_cmp++; if (sh !== esh) begin n_bad++; $display("FAIL rand%0d_short got=%b want=%b", f, sh, esh); end
      n_cmp++; if (s !== held_s) begin n_bad++; $display("FAIL rand%0d_sigma got=%0d want=%0d", f, s, held_s); end
      n_cmp++; if (m !== held_m) begin n_bad++; $display("FAIL rand%0d_imean got=%0d want=%0d", f, m, held_m); end
      if (!esh) begin
        n_cmp++; if (l !== 1) begin n_bad++; $display("FAIL rand%0d_latency got=%0d want=1", f, l); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_const();
    test_alternating();
    test_short_frame();
    test_restart();
    test_overlong();
    test_reset_mid_frame();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
